midi_uart_rx: RTL and testbench

- Serial MIDI receiver: converts one synchronized MIDI input line (31250 baud, 8N1, LSB first) into parallel bytes with a one-cycle valid strobe.
- Sits directly downstream of the per-port input synchronizers. It is the receive counterpart of uart_tx. Its byte/strobe output feeds the routing logic and the uart_tx data/tx_strobe pair.
- One instance per MIDI input port.

---
 rtl/midi_uart_rx.sv | 140 ++++++++++++++
 tb/tb_midi_uart_rx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1, LSB first, mid-bit sampling.
// Re-arms only after a full idle period, so mid-byte starts are ignored.
module midi_uart_rx #(
  parameter int CLKS_PER_BIT  = 384,
  parameter int IDLE_ARM_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    ARM_END  = 4'(IDLE_ARM_BITS - 1);

  typedef enum logic [2:0] {
    ARM, IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    bits;
  logic [7:0]    shreg;
  logic          tick_half;
  logic          tick_bit;
  logic          dv_n;
  logic          fe_n;
  logic          busy_n;

  assign tick_half = (cnt == HALF_END);
  assign tick_bit  = (cnt == BIT_END);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARM;
    else      state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      ARM: begin
        if (rx && tick_bit && bits == ARM_END)
          state_n = IDLE;
      end
      IDLE: begin
        if (!rx) state_n = START;
      end
      START: begin
        if (tick_half) state_n = rx ? IDLE : DATA;
      end
      DATA: begin
        if (tick_bit && bits == 4'd7)
          state_n = STOP;
      end
      STOP: begin
        if (tick_bit) state_n = rx ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx) state_n = ARM;
      end
      default: state_n = ARM;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    dv_n   = (state == STOP) && tick_bit && rx;
    fe_n   = (state == STOP) && tick_bit && !rx;
    busy_n = (state_n == START) || (state_n == DATA)
          || (state_n == STOP);
  end

  // Bit-time counter, bit counter and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      bits  <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        ARM: begin
          if (!rx) begin
            cnt  <= '0;
            bits <= '0;
          end else if (tick_bit) begin
            cnt  <= '0;
            bits <= bits + 4'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START: begin
          if (tick_half) cnt <= '0;
          else           cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (tick_bit) begin
            cnt   <= '0;
            bits  <= bits + 4'd1;
            shreg <= {rx, shreg[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_bit) cnt <= '0;
          else          cnt <= cnt + 1'b1;
        end
        default: begin
          cnt  <= '0;
          bits <= '0;
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= dv_n;
      frame_err  <= fe_n;
      busy       <= busy_n;
      if (dv_n) data <= shreg;
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: directed frames plus random streams,
// checked cycle by cycle against a sample-point reference model.
module tb_midi_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
  localparam int A = N;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  midi_uart_rx #(
    .CLKS_PER_BIT (N),
    .IDLE_ARM_BITS(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_e = 0;

  bit         line[$];
  bit         t_dv[$];
  bit         t_fe[$];
  bit         t_bz[$];
  logic [7:0] t_data[$];
  int         v_cyc[$];

  // line[k] is rx at the k-th edge after release;
  // trace entry k holds the outputs of cycle k+1
  always @(posedge clk) begin
    if (rst) begin
      line.push_back(rx);
      cyc++;
      #1;
      t_dv.push_back(data_valid);
      t_fe.push_back(frame_err);
      t_bz.push_back(busy);
      t_data.push_back(data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    last_e = cyc;
    repeat (N - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive(b[i], N);
    drive(stop, N);
  endtask

  task automatic seg_begin(input bit lvl);
    @(negedge clk);
    rst = 1'b0;
    rx  = lvl;
    #1;
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    line.delete();
    t_dv.delete();
    t_fe.delete();
    t_bz.delete();
    t_data.delete();
    cyc = 0;
    rst = 1'b1;
  endtask

  // Expected behaviour from the frame rules: find start edge E,
  // sample at E+H+k*N, strobe at S+1, re-arm after A high cycles.
  task automatic run_model(output int mdv, output int mfe,
                           output int mbz, output int mdt);
    int L;
    int t;
    int run;
    int E;
    int S;
    bit armed;
    logic [7:0] b;
    logic [7:0] cur;
    bit e_dv[];
    bit e_fe[];
    bit e_bz[];
    logic [7:0] e_b[];
    L = line.size();
    e_dv = new[L + 2];
    e_fe = new[L + 2];
    e_bz = new[L + 2];
    e_b  = new[L + 2];
    t = 0;
    run = 0;
    armed = 0;
    while (t < L) begin
      if (!armed) begin
        run = line[t] ? run + 1 : 0;
        if (run == A) armed = 1;
        t++;
      end else if (line[t]) begin
        t++;
      end else begin
        E = t;
        if (E + H >= L) begin
          for (int c = E + 1; c <= L; c++) e_bz[c] = 1;
          break;
        end
        if (line[E + H]) begin
          for (int c = E + 1; c <= E + H; c++) e_bz[c] = 1;
          t = E + H + 1;
        end else begin
          S = E + H + 9 * N;
          if (S >= L) begin
            for (int c = E + 1; c <= L; c++) e_bz[c] = 1;
            break;
          end
          for (int c = E + 1; c <= S; c++) e_bz[c] = 1;
          for (int i = 0; i < 8; i++)
            b[i] = line[E + H + (i + 1) * N];
          t = S + 1;
          if (line[S]) begin
            e_dv[S + 1] = 1;
            e_b[S + 1]  = b;
          end else begin
            e_fe[S + 1] = 1;
            while (t < L && !line[t]) t++;
            t++;
            armed = 0;
            run = 0;
          end
        end
      end
    end
    mdv = 0;
    mfe = 0;
    mbz = 0;
    mdt = 0;
    cur = 8'h00;
    for (int c = 1; c <= L && c <= t_dv.size(); c++) begin
      if (e_dv[c]) cur = e_b[c];
      if (t_dv[c - 1] !== e_dv[c]) mdv++;
      if (t_fe[c - 1] !== e_fe[c]) mfe++;
      if (t_bz[c - 1] !== e_bz[c]) mbz++;
      if (t_data[c - 1] !== cur) mdt++;
    end
  endtask

  task automatic seg_end(input int exp_nv, input int exp_last,
                         input int exp_nfe);
    int mdv;
    int mfe;
    int mbz;
    int mdt;
    int nfe;
    logic [7:0] last;
    run_model(mdv, mfe, mbz, mdt);
    check("valid_trace_diffs", mdv, 0);
    check("ferr_trace_diffs", mfe, 0);
    check("busy_trace_diffs", mbz, 0);
    check("data_trace_diffs", mdt, 0);
    v_cyc.delete();
    nfe = 0;
    last = 8'h00;
    foreach (t_dv[i]) begin
      if (t_dv[i]) begin
        v_cyc.push_back(i + 1);
        last = t_data[i];
      end
      if (t_fe[i]) nfe++;
    end
    if (exp_nv >= 0) begin
      check("n_valid", v_cyc.size(), exp_nv);
      check("last_byte", last, exp_last);
      check("n_ferr", nfe, exp_nfe);
    end
  endtask

  int gap;
  int run_low;
  int k;

  initial begin
    // valid byte and its latency
    seg_begin(1);
    drive(1, 20);
    send(8'h90, 1);
    drive(1, 20);
    seg_end(1, 8'h90, 0);
    check("latency",
          v_cyc.size() > 0 ? v_cyc[0] - last_e : -1, 153);

    // start glitch, then a clean frame
    seg_begin(1);
    drive(1, 20);
    drive(0, 3);
    drive(1, 20);
    send(8'h45, 1);
    drive(1, 20);
    seg_end(1, 8'h45, 0);

    // framing error holds data, then re-arm
    seg_begin(1);
    drive(1, 20);
    send(8'h11, 1);
    drive(1, 10);
    send(8'hAA, 0);
    drive(0, 40);
    drive(1, 20);
    send(8'h12, 1);
    drive(1, 20);
    seg_end(2, 8'h12, 1);

    // reset during bit 4 of 0x55
    seg_begin(1);
    drive(1, 20);
    send(8'hA5, 1);
    drive(1, 20);
    drive(0, N);
    drive(1, N);
    drive(0, N);
    drive(1, N);
    drive(0, N);
    drive(1, H);
    seg_end(1, 8'hA5, 0);
    seg_begin(0);
    drive(0, 10);
    drive(1, 16);
    send(8'h3C, 1);
    drive(1, 20);
    seg_end(1, 8'h3C, 0);

    // line low from release: first frame is not decoded
    seg_begin(0);
    drive(0, 30);
    send(8'h00, 1);
    drive(1, 20);
    send(8'h3C, 1);
    drive(1, 20);
    seg_end(1, 8'h3C, 0);

    // back-to-back frames
    seg_begin(1);
    drive(1, 20);
    send(8'h3C, 1);
    send(8'h7F, 1);
    drive(1, 20);
    seg_end(2, 8'h7F, 0);
    check("b2b_spacing",
          v_cyc.size() >= 2 ? v_cyc[1] - v_cyc[0] : 0, 160);

    // running-status stream
    seg_begin(1);
    drive(1, 20);
    send(8'h90, 1);
    send(8'h3C, 1);
    send(8'h64, 1);
    send(8'h3E, 1);
    send(8'h64, 1);
    drive(1, 20);
    seg_end(5, 8'h64, 0);
    gap = 0;
    run_low = 0;
    if (v_cyc.size() == 5) begin
      for (int c = v_cyc[0]; c < v_cyc[4]; c++) begin
        run_low = t_bz[c - 1] ? 0 : run_low + 1;
        if (run_low > gap) gap = run_low;
      end
    end
    check("busy_gap_le8", (gap > 0) && (gap <= 8), 1);

    // random streams against the model
    for (int s = 0; s < 6; s++) begin
      seg_begin(1);
      drive(1, $urandom_range(0, 30));
      for (int f = 0; f < 8; f++) begin
        k = $urandom_range(0, 9);
        if (k == 0) begin
          drive(0, $urandom_range(1, H - 1));
          drive(1, $urandom_range(1, 20));
        end else if (k == 1) begin
          send(8'($urandom), 0);
          drive(0, $urandom_range(0, 30));
          drive(1, $urandom_range(1, 25));
        end else begin
          send(8'($urandom), 1);
          drive(1, $urandom_range(0, 20));
        end
      end
      drive(1, 30);
      seg_end(-1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
